coord_mapper_pipe: RTL and testbench
====================================

// Module: coord_mapper_pipe
// PURPOSE
//  Pipelined, parametrised successor of the normalised-coordinate-to-pixel mapper.
//  Converts signed normalised (X,Y) points to screen pixel coordinates, applying a
//  per-point pan offset, an optional Y flip and a selectable clip policy (drop or
//  saturate). Sits between the geometry stage and the pixel writer, with valid/ready on both sides.
// PARAMETERS
//  IN_W       8    input coordinate width, signed two's complement
//  OUT_W      16   output pixel coordinate width; X_RESOL,Y_RESOL <= 2**OUT_W
//  X_RESOL    320  horizontal resolution, pixels
//  Y_RESOL    200  vertical resolution, pixels
//  FLIP_Y     0    1: y_pix = Y_RESOL-1-y (origin at bottom)
//  CLIP_MODE  0    0: drop out-of-range points; 1: saturate to screen edge
// PORTS
//  ACLK       in   1       clock, all logic on rising edge
//  ARESET     in   1       asynchronous reset, active-high
//  ENB        in   1       pipeline enable; 0 freezes all stages and holds outputs
//  CLR_STATS  in   1       one-cycle pulse, clears DROP_CNT
//  PAN_X      in   IN_W+1  signed X pan, sampled with the input point
//  PAN_Y      in   IN_W+1  signed Y pan, sampled with the input point
//  IN_VALID   in   1       input point valid
//  IN_READY   out  1       input accepted when IN_VALID & IN_READY
//  XCOORD     in   IN_W    signed normalised X
//  YCOORD     in   IN_W    signed normalised Y
//  OUT_VALID  out  1       output point valid
//  OUT_READY  in   1       consumer ready
//  XOUT       out  OUT_W   pixel X
//  YOUT       out  OUT_W   pixel Y
//  OUT_CLIP   out  1       point was saturated (CLIP_MODE=1 only, else 0)
//  DROP_CNT   out  16      points dropped by clipping, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: all stage valids 0, OUT_VALID=0, XOUT=YOUT=0, OUT_CLIP=0, DROP_CNT=0.
//  Pipeline: 3 stages S1,S2,S3; latency 3 ACLK from accept to OUT_VALID, no stall.
//  Advance = ENB & (!S3.valid | OUT_READY); all stages shift together on advance.
//  IN_READY = advance (combinational); bubbles propagate, no reordering.
//  S1: u = XCOORD + 2**(IN_W-1) + PAN_X, computed signed IN_W+2 bits (no wrap);
//      same for Y. In range iff 0 <= u <= 2**IN_W-1, else out-of-range.
//      Out-of-range, CLIP_MODE=0: S2.valid=0, DROP_CNT+=1 on that advance.
//      Out-of-range, CLIP_MODE=1: u clamped to 0 or 2**IN_W-1, clip flag set.
//  S2: p = u * RES, unsigned, IN_W+OUT_W bits, registered.
//  S3: pix = p >> IN_W (floor, always < RES); if FLIP_Y, y = Y_RESOL-1-y;
//      saturated edges: low clamp -> 0, high clamp -> RES-1 (before flip).
//  Outputs hold stable while OUT_VALID & !OUT_READY.
//  ENB=0: no advance, IN_READY=0, all registers hold, DROP_CNT holds.
//  DROP_CNT: CLR_STATS has priority over a coincident drop (result 0); stops at FFFF.
//  Either axis out of range clips the whole point (drop both / flag once).
//  ARESET mid-operation: in-flight points discarded, outputs to reset values
//  immediately (asynchronous), first accept possible on first edge after release.
// TESTING
//  IN_W=8,320x200: X=0,Y=0,pan 0 -> after 3 clk XOUT=160,YOUT=100,OUT_CLIP=0.
//  X=-128,Y=127 -> XOUT=0,YOUT=199; FLIP_Y=1 same input -> YOUT=0.
//  CLIP_MODE=0, X=127,PAN_X=+10 -> no OUT_VALID for it, DROP_CNT=1; CLR_STATS -> 0.
//  CLIP_MODE=1, X=127,PAN_X=+10 -> XOUT=319, OUT_CLIP=1; X=-128,PAN_X=-5 -> XOUT=0.
//  Stream 5 points, OUT_READY=0 from cycle 3: IN_READY drops, 3 held, no loss,
//  release -> all 5 out in order; ENB=0 mid-stream freezes all outputs.
//  ARESET asserted with 3 points in flight -> OUT_VALID=0, DROP_CNT=0 at once.

Source files
------------

// File: rtl/coord_mapper_pipe.sv
// coord_mapper_pipe: 3-stage normalised (X,Y) to pixel mapper with pan, optional Y flip and drop/saturate clipping.
module coord_mapper_pipe #(
    parameter int IN_W      = 8,
    parameter int OUT_W     = 16,
    parameter int X_RESOL   = 320,
    parameter int Y_RESOL   = 200,
    parameter int FLIP_Y    = 0,
    parameter int CLIP_MODE = 0
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              ENB,
    input  logic              CLR_STATS,
    input  logic [IN_W:0]     PAN_X,
    input  logic [IN_W:0]     PAN_Y,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [IN_W-1:0]   XCOORD,
    input  logic [IN_W-1:0]   YCOORD,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [OUT_W-1:0]  XOUT,
    output logic [OUT_W-1:0]  YOUT,
    output logic              OUT_CLIP,
    output logic [15:0]       DROP_CNT
);
    localparam int UW = IN_W + 2;
    localparam int PW = IN_W + OUT_W;
    localparam logic [UW-1:0]    BIAS = UW'(2 ** (IN_W - 1));
    localparam logic [PW-1:0]    XR   = PW'(X_RESOL);
    localparam logic [PW-1:0]    YR   = PW'(Y_RESOL);
    localparam logic [OUT_W-1:0] XMAX = OUT_W'(X_RESOL - 1);
    localparam logic [OUT_W-1:0] YMAX = OUT_W'(Y_RESOL - 1);
    localparam logic             SAT  = (CLIP_MODE != 0);
    logic              adv, s1_v, s2_v, s3_v;
    logic [UW-1:0]     ux_n, uy_n, s1_ux, s1_uy;
    logic [PW-1:0]     s2_px, s2_py;
    logic              s2_xhi, s2_yhi, s2_clip;
    logic              x_lo, x_hi, y_lo, y_hi, oor;
    logic [IN_W-1:0]   cx, cy;
    logic [OUT_W-1:0]  xp, ya, yp;

    assign adv       = ENB & (~s3_v | OUT_READY);
    assign IN_READY  = adv;
    assign OUT_VALID = s3_v;

    // u is IN_W+2 bits signed, wide enough that bias plus any pan never wraps
    always_comb begin
        ux_n = {{2{XCOORD[IN_W-1]}}, XCOORD} + BIAS + {PAN_X[IN_W], PAN_X};
        uy_n = {{2{YCOORD[IN_W-1]}}, YCOORD} + BIAS + {PAN_Y[IN_W], PAN_Y};
        x_lo = s1_ux[UW-1];
        x_hi = ~s1_ux[UW-1] & s1_ux[IN_W];
        y_lo = s1_uy[UW-1];
        y_hi = ~s1_uy[UW-1] & s1_uy[IN_W];
        oor  = x_lo | x_hi | y_lo | y_hi;
        cx   = x_lo ? '0 : x_hi ? '1 : s1_ux[IN_W-1:0];
        cy   = y_lo ? '0 : y_hi ? '1 : s1_uy[IN_W-1:0];
        // a high clamp maps to the last pixel, which floor(255*RES/256) would miss
        xp   = s2_xhi ? XMAX : OUT_W'(s2_px >> IN_W);
        ya   = s2_yhi ? YMAX : OUT_W'(s2_py >> IN_W);
        yp   = (FLIP_Y != 0) ? YMAX - ya : ya;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            s1_v     <= 1'b0;
            s2_v     <= 1'b0;
            s3_v     <= 1'b0;
            s1_ux    <= '0;
            s1_uy    <= '0;
            s2_px    <= '0;
            s2_py    <= '0;
            s2_xhi   <= 1'b0;
            s2_yhi   <= 1'b0;
            s2_clip  <= 1'b0;
            XOUT     <= '0;
            YOUT     <= '0;
            OUT_CLIP <= 1'b0;
        end else if (adv) begin
            s1_v     <= IN_VALID;
            s1_ux    <= ux_n;
            s1_uy    <= uy_n;
            s2_v     <= s1_v & (~oor | SAT);
            s2_px    <= PW'(cx) * XR;
            s2_py    <= PW'(cy) * YR;
            s2_xhi   <= x_hi;
            s2_yhi   <= y_hi;
            s2_clip  <= oor;
            s3_v     <= s2_v;
            XOUT     <= xp;
            YOUT     <= yp;
            OUT_CLIP <= SAT & s2_clip;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            DROP_CNT <= '0;
        else if (CLR_STATS)
            DROP_CNT <= '0;
        else if (adv & s1_v & oor & ~SAT & (DROP_CNT != 16'hFFFF))
            DROP_CNT <= DROP_CNT + 16'd1;
    end
endmodule

// File: tb/tb_coord_mapper_pipe.sv
// tb_coord_mapper_pipe: directed checks of three mapper variants (drop, drop+flip, saturate) driven in parallel.
module tb_coord_mapper_pipe;
    logic ACLK = 1'b0, ARESET = 1'b1, ENB = 1'b0, CLR_STATS = 1'b0;
    logic IN_VALID = 1'b0, OUT_READY = 1'b1;
    logic signed [8:0] PAN_X = '0, PAN_Y = '0;
    logic signed [7:0] XCOORD = '0, YCOORD = '0;
    logic b_ir, b_ov, b_clip, f_ir, f_ov, f_clip, s_ir, s_ov, s_clip;
    logic [15:0] b_x, b_y, b_drop, f_x, f_y, f_drop, s_x, s_y, s_drop;
    int tests = 0, fails = 0;

    always #5 ACLK = ~ACLK;

    coord_mapper_pipe #(.FLIP_Y(0), .CLIP_MODE(0)) u_base (
        .ACLK(ACLK), .ARESET(ARESET), .ENB(ENB), .CLR_STATS(CLR_STATS), .PAN_X(PAN_X), .PAN_Y(PAN_Y),
        .IN_VALID(IN_VALID), .IN_READY(b_ir), .XCOORD(XCOORD), .YCOORD(YCOORD), .OUT_VALID(b_ov),
        .OUT_READY(OUT_READY), .XOUT(b_x), .YOUT(b_y), .OUT_CLIP(b_clip), .DROP_CNT(b_drop));
    coord_mapper_pipe #(.FLIP_Y(1), .CLIP_MODE(0)) u_flip (
        .ACLK(ACLK), .ARESET(ARESET), .ENB(ENB), .CLR_STATS(CLR_STATS), .PAN_X(PAN_X), .PAN_Y(PAN_Y),
        .IN_VALID(IN_VALID), .IN_READY(f_ir), .XCOORD(XCOORD), .YCOORD(YCOORD), .OUT_VALID(f_ov),
        .OUT_READY(OUT_READY), .XOUT(f_x), .YOUT(f_y), .OUT_CLIP(f_clip), .DROP_CNT(f_drop));
    coord_mapper_pipe #(.FLIP_Y(0), .CLIP_MODE(1)) u_sat (
        .ACLK(ACLK), .ARESET(ARESET), .ENB(ENB), .CLR_STATS(CLR_STATS), .PAN_X(PAN_X), .PAN_Y(PAN_Y),
        .IN_VALID(IN_VALID), .IN_READY(s_ir), .XCOORD(XCOORD), .YCOORD(YCOORD), .OUT_VALID(s_ov),
        .OUT_READY(OUT_READY), .XOUT(s_x), .YOUT(s_y), .OUT_CLIP(s_clip), .DROP_CNT(s_drop));

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset;
        #2;
        tests++; if (b_ov !== 1'b0) begin fails++; $display("FAIL reset_ov got %0b want 0", b_ov); end
        tests++; if (b_x !== 16'd0 || b_y !== 16'd0) begin fails++; $display("FAIL reset_xy got %0d,%0d want 0,0", b_x, b_y); end
        tests++; if (s_clip !== 1'b0) begin fails++; $display("FAIL reset_clip got %0b want 0", s_clip); end
        tests++; if (b_drop !== 16'd0) begin fails++; $display("FAIL reset_drop got %0d want 0", b_drop); end
        tick;
        ARESET = 1'b0;
        ENB = 1'b1;
    endtask

    task automatic test_center;
        XCOORD = 8'sd0; YCOORD = 8'sd0; IN_VALID = 1'b1;
        #1;
        tests++; if (b_ir !== 1'b1) begin fails++; $display("FAIL center_ready got %0b want 1", b_ir); end
        tick;
        IN_VALID = 1'b0;
        tick;
        tests++; if (b_ov !== 1'b0) begin fails++; $display("FAIL center_early_valid got %0b want 0", b_ov); end
        tick;
        tests++; if (b_ov !== 1'b1) begin fails++; $display("FAIL center_valid got %0b want 1", b_ov); end
        tests++; if (b_x !== 16'd160 || b_y !== 16'd100) begin fails++; $display("FAIL center_xy got %0d,%0d want 160,100", b_x, b_y); end
        tests++; if (s_clip !== 1'b0) begin fails++; $display("FAIL center_clip got %0b want 0", s_clip); end
        tick;
    endtask

    task automatic test_back_to_back;
        XCOORD = -8'sd128; YCOORD = 8'sd127; IN_VALID = 1'b1;
        tick;
        XCOORD = 8'sd127; YCOORD = 8'sd0;
        tick;
        IN_VALID = 1'b0;
        tick;
        tests++; if (b_ov !== 1'b1 || b_x !== 16'd0 || b_y !== 16'd199) begin fails++; $display("FAIL corner_base got v%0b %0d,%0d want v1 0,199", b_ov, b_x, b_y); end
        tests++; if (f_x !== 16'd0 || f_y !== 16'd0) begin fails++; $display("FAIL corner_flip got %0d,%0d want 0,0", f_x, f_y); end
        tests++; if (s_clip !== 1'b0) begin fails++; $display("FAIL corner_clip got %0b want 0", s_clip); end
        tick;
        tests++; if (b_ov !== 1'b1 || b_x !== 16'd318 || b_y !== 16'd100) begin fails++; $display("FAIL edge_max got v%0b %0d,%0d want v1 318,100", b_ov, b_x, b_y); end
        tests++; if (f_y !== 16'd99) begin fails++; $display("FAIL edge_flip_y got %0d want 99", f_y); end
        tick;
        tests++; if (b_ov !== 1'b0) begin fails++; $display("FAIL b2b_drain got %0b want 0", b_ov); end
    endtask

    task automatic test_clip;
        XCOORD = 8'sd127; YCOORD = 8'sd0; PAN_X = 9'sd10; IN_VALID = 1'b1;
        tick;
        IN_VALID = 1'b0; PAN_X = '0;
        tick;
        tests++; if (b_drop !== 16'd1 || f_drop !== 16'd1) begin fails++; $display("FAIL drop_cnt got %0d,%0d want 1,1", b_drop, f_drop); end
        tests++; if (s_drop !== 16'd0) begin fails++; $display("FAIL sat_drop_cnt got %0d want 0", s_drop); end
        tick;
        tests++; if (b_ov !== 1'b0) begin fails++; $display("FAIL drop_valid got %0b want 0", b_ov); end
        tests++; if (s_ov !== 1'b1 || s_x !== 16'd319 || s_y !== 16'd100 || s_clip !== 1'b1) begin fails++; $display("FAIL sat_hi got v%0b %0d,%0d c%0b want v1 319,100 c1", s_ov, s_x, s_y, s_clip); end
        tick;
        CLR_STATS = 1'b1;
        tick;
        CLR_STATS = 1'b0;
        tests++; if (b_drop !== 16'd0 || f_drop !== 16'd0) begin fails++; $display("FAIL clr_stats got %0d,%0d want 0,0", b_drop, f_drop); end
        PAN_X = 9'sd10; IN_VALID = 1'b1;
        tick;
        IN_VALID = 1'b0; PAN_X = '0; CLR_STATS = 1'b1;
        tick;
        CLR_STATS = 1'b0;
        tests++; if (b_drop !== 16'd0) begin fails++; $display("FAIL clr_priority got %0d want 0", b_drop); end
        tick; tick;
        XCOORD = -8'sd128; PAN_X = -9'sd5; IN_VALID = 1'b1;
        tick;
        IN_VALID = 1'b0; PAN_X = '0;
        tick; tick;
        tests++; if (s_ov !== 1'b1 || s_x !== 16'd0 || s_y !== 16'd100 || s_clip !== 1'b1) begin fails++; $display("FAIL sat_lo got v%0b %0d,%0d c%0b want v1 0,100 c1", s_ov, s_x, s_y, s_clip); end
        tests++; if (b_ov !== 1'b0 || b_drop !== 16'd1) begin fails++; $display("FAIL drop_lo got v%0b cnt %0d want v0 cnt 1", b_ov, b_drop); end
        XCOORD = 8'sd0; YCOORD = 8'sd127; PAN_Y = 9'sd1; IN_VALID = 1'b1;
        tick;
        IN_VALID = 1'b0; PAN_Y = '0; YCOORD = 8'sd0;
        tick; tick;
        tests++; if (s_ov !== 1'b1 || s_x !== 16'd160 || s_y !== 16'd199 || s_clip !== 1'b1) begin fails++; $display("FAIL sat_y got v%0b %0d,%0d c%0b want v1 160,199 c1", s_ov, s_x, s_y, s_clip); end
        tests++; if (b_ov !== 1'b0 || b_drop !== 16'd2) begin fails++; $display("FAIL drop_y got v%0b cnt %0d want v0 cnt 2", b_ov, b_drop); end
        tick;
    endtask

    task automatic test_stall;
        int in_i = 0, out_i = 0, want;
        logic fire_in, fire_out;
        for (int c = 0; c < 20; c++) begin
            OUT_READY = (c < 2 || c >= 6);
            IN_VALID = (in_i < 5);
            XCOORD = 8'(in_i * 16);
            #1;
            if (c >= 3 && c < 6) begin
                tests++; if (b_ir !== 1'b0) begin fails++; $display("FAIL stall_ready c%0d got %0b want 0", c, b_ir); end
                tests++; if (b_ov !== 1'b1 || b_x !== 16'd160) begin fails++; $display("FAIL stall_hold c%0d got v%0b %0d want v1 160", c, b_ov, b_x); end
            end
            fire_in = IN_VALID & b_ir;
            fire_out = b_ov & OUT_READY;
            if (fire_out) begin
                want = (out_i < 5) ? 160 + 20 * out_i : -1;
                tests++; if (int'(b_x) !== want || b_y !== 16'd100) begin fails++; $display("FAIL stream_out%0d got %0d,%0d want %0d,100", out_i, b_x, b_y, want); end
                out_i++;
            end
            tick;
            if (fire_in) in_i++;
        end
        tests++; if (out_i !== 5) begin fails++; $display("FAIL stream_count got %0d want 5", out_i); end
        IN_VALID = 1'b0; OUT_READY = 1'b1;
    endtask

    task automatic test_enb;
        IN_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            XCOORD = 8'(i * 16);
            tick;
        end
        ENB = 1'b0; XCOORD = 8'sd48;
        #1;
        tests++; if (b_ir !== 1'b0) begin fails++; $display("FAIL enb_ready got %0b want 0", b_ir); end
        for (int i = 0; i < 3; i++) begin
            tick;
            tests++; if (b_ov !== 1'b1 || b_x !== 16'd160) begin fails++; $display("FAIL enb_freeze%0d got v%0b %0d want v1 160", i, b_ov, b_x); end
        end
        ENB = 1'b1; IN_VALID = 1'b0;
        tick;
        tests++; if (b_ov !== 1'b1 || b_x !== 16'd180) begin fails++; $display("FAIL enb_resume1 got v%0b %0d want v1 180", b_ov, b_x); end
        tick;
        tests++; if (b_ov !== 1'b1 || b_x !== 16'd200) begin fails++; $display("FAIL enb_resume2 got v%0b %0d want v1 200", b_ov, b_x); end
        tick;
        tests++; if (b_ov !== 1'b0) begin fails++; $display("FAIL enb_no_extra got %0b want 0", b_ov); end
    endtask

    task automatic test_async_reset;
        XCOORD = 8'sd127; PAN_X = 9'sd10; IN_VALID = 1'b1;
        tick;
        PAN_X = '0;
        for (int i = 0; i < 3; i++) begin
            XCOORD = 8'(i * 16);
            tick;
        end
        IN_VALID = 1'b0;
        tests++; if (b_ov !== 1'b1 || b_drop !== 16'd3) begin fails++; $display("FAIL arst_pre got v%0b cnt %0d want v1 cnt 3", b_ov, b_drop); end
        #1 ARESET = 1'b1;
        #1;
        tests++; if (b_ov !== 1'b0 || f_ov !== 1'b0 || s_ov !== 1'b0) begin fails++; $display("FAIL arst_valid got %0b%0b%0b want 000", b_ov, f_ov, s_ov); end
        tests++; if (b_drop !== 16'd0 || b_x !== 16'd0) begin fails++; $display("FAIL arst_state got cnt %0d x %0d want 0,0", b_drop, b_x); end
        #1 ARESET = 1'b0;
        XCOORD = 8'sd0; IN_VALID = 1'b1;
        #1;
        tests++; if (b_ir !== 1'b1) begin fails++; $display("FAIL arst_ready got %0b want 1", b_ir); end
        tick;
        IN_VALID = 1'b0;
        tick; tick;
        tests++; if (b_ov !== 1'b1 || b_x !== 16'd160 || b_y !== 16'd100) begin fails++; $display("FAIL arst_first got v%0b %0d,%0d want v1 160,100", b_ov, b_x, b_y); end
    endtask

    initial begin
        test_reset;
        test_center;
        test_back_to_back;
        test_clip;
        test_stall;
        test_enb;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
